// File: rtl/logic_serial_pkg.sv
// logic_serial_pkg: opcode encodings and FSM states shared by the serial logic unit
package logic_serial_pkg;
   localparam logic [2:0] OP_NOT  = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_XNOR = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;
endpackage

// File: rtl/logic_digit_op.sv
// logic_digit_op: one digit-wide bitwise slice shared by every digit of an operation
module logic_digit_op
   import logic_serial_pkg::*;
#(
   parameter int DIGIT = 4
) (
   input  logic [2:0]       op_i,
   input  logic [DIGIT-1:0] x_i,
   input  logic [DIGIT-1:0] y_i,
   output logic [DIGIT-1:0] z_o
);
   // eight-way function select; PASS falls through to the default
   always_comb begin
      case (op_i)
         OP_NOT:  z_o = ~x_i;
         OP_AND:  z_o = x_i & y_i;
         OP_OR:   z_o = x_i | y_i;
         OP_XOR:  z_o = x_i ^ y_i;
         OP_NOR:  z_o = ~(x_i | y_i);
         OP_NAND: z_o = ~(x_i & y_i);
         OP_XNOR: z_o = ~(x_i ^ y_i);
         default: z_o = x_i;
      endcase
   end
endmodule

// File: rtl/logic_serial_unit.sv
// logic_serial_unit: digit-serial bitwise logic unit, LSB digit first, with zero flag
module logic_serial_unit
   import logic_serial_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = NDIG > 1 ? $clog2(NDIG) : 1;

   if (WIDTH % DIGIT != 0) begin : g_width_chk
      $error("logic_serial_unit: WIDTH must be a multiple of DIGIT");
   end

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
   logic [2:0]       op_q;
   logic             zero_q;
   logic [DIGIT-1:0] slice;

   logic_digit_op #(.DIGIT(DIGIT)) u_digit (
      .op_i(op_q),
      .x_i (a_q[DIGIT-1:0]),
      .y_i (b_q[DIGIT-1:0]),
      .z_o (slice)
   );

   assign res_d       = {slice, res_q[WIDTH-1:DIGIT]};
   assign in_ready_o  = state_q == S_IDLE;
   assign out_valid_o = state_q == S_DONE;
   assign result_o    = res_q;
   assign zero_o      = zero_q;

   // capture on handshake, shift one digit per RUN cycle, hold result until consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid_i) begin
               a_q     <= a_i;
               b_q     <= b_i;
               op_q    <= op_i;
               cnt_q   <= '0;
               state_q <= S_RUN;
            end
            S_RUN: begin
               a_q   <= a_q >> DIGIT;
               b_q   <= b_q >> DIGIT;
               res_q <= res_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(NDIG - 1)) begin
                  zero_q  <= ~|res_d;
                  state_q <= S_DONE;
               end
            end
            S_DONE: if (out_ready_i) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule
